// File: rtl/clock_mode_ctrl_if.sv
// Button/status inputs and mode/strobe outputs of the clock mode controller.
// master: the controller itself; slave: the buttons and datapath around it.
interface clock_mode_ctrl_if;
  logic       btn_mode;
  logic       btn_sel;
  logic       btn_inc;
  logic       btn_start;
  logic       btn_clr;
  logic       is_stopwatch_running;
  logic       is_timer_running;
  logic       alarm_trigger;
  logic       set_time_mode;
  logic       stopwatch_mode;
  logic       timer_mode;
  logic       set_timer_mode;
  logic       set_alarm_mode;
  logic       inc_hours;
  logic       inc_minutes;
  logic       inc_seconds;
  logic       inc_timer_hours;
  logic       inc_timer_minutes;
  logic       inc_timer_seconds;
  logic       inc_alarm_hours;
  logic       inc_alarm_minutes;
  logic       start_stopwatch;
  logic       stop_stopwatch;
  logic       reset_stopwatch;
  logic       start_timer;
  logic       stop_timer;
  logic       reset_timer;
  logic       alarm_reset;
  logic [1:0] field_sel;
  logic [2:0] mode_state;

  modport master (
    input  btn_mode, btn_sel, btn_inc, btn_start, btn_clr,
           is_stopwatch_running, is_timer_running, alarm_trigger,
    output set_time_mode, stopwatch_mode, timer_mode, set_timer_mode, set_alarm_mode,
           inc_hours, inc_minutes, inc_seconds,
           inc_timer_hours, inc_timer_minutes, inc_timer_seconds,
           inc_alarm_hours, inc_alarm_minutes,
           start_stopwatch, stop_stopwatch, reset_stopwatch,
           start_timer, stop_timer, reset_timer, alarm_reset,
           field_sel, mode_state
  );

  modport slave (
    output btn_mode, btn_sel, btn_inc, btn_start, btn_clr,
           is_stopwatch_running, is_timer_running, alarm_trigger,
    input  set_time_mode, stopwatch_mode, timer_mode, set_timer_mode, set_alarm_mode,
           inc_hours, inc_minutes, inc_seconds,
           inc_timer_hours, inc_timer_minutes, inc_timer_seconds,
           inc_alarm_hours, inc_alarm_minutes,
           start_stopwatch, stop_stopwatch, reset_stopwatch,
           start_timer, stop_timer, reset_timer, alarm_reset,
           field_sel, mode_state
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Clock UI sequencer: turns raw buttons into mode levels and one-cycle
// command strobes for the clock datapath. All outputs are registered.
// Optional hold-to-repeat on btn_inc: define CLOCK_MODE_CTRL_AUTOREPEAT_EN.
module clock_mode_ctrl #(
  parameter int unsigned REPEAT_DELAY = 2,
  parameter int unsigned TIMEOUT      = 30,
  parameter int unsigned CNT_W        = 6
) (
  input logic               clk_1Hz,
  input logic               reset,
  clock_mode_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    DISP_TIME = 3'd0,
    SET_TIME  = 3'd1,
    STOPWATCH = 3'd2,
    TIMER     = 3'd3,
    SET_TIMER = 3'd4,
    SET_ALARM = 3'd5
  } state_e;

  // Button bit positions
  localparam int unsigned B_MODE = 0, B_SEL = 1, B_INC = 2, B_START = 3, B_CLR = 4;
  // Strobe bit positions; the inc_* groups are laid out hours/minutes/seconds
  localparam int unsigned S_SW_START = 8, S_SW_STOP = 9, S_SW_RST = 10;
  localparam int unsigned S_TM_START = 11, S_TM_STOP = 12, S_TM_RST = 13, S_ALM_RST = 14;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  if (CNT_W < 1 || REPEAT_DELAY < 1 || (TIMEOUT >> CNT_W) != 0 || (REPEAT_DELAY >> CNT_W) != 0)
  begin : g_param_chk
    $error("clock_mode_ctrl: CNT_W too narrow or REPEAT_DELAY < 1");
  end

  state_e           state_q, state_d;
  logic [1:0]       field_sel_q, field_sel_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [4:0]       btn, btn_q, btn_d, rise;
  logic [14:0]      strb_q, strb_d;
  logic [4:0]       mode_lvl_q, mode_lvl_d;
  logic             set_mode;
  logic             inc_fire;
  logic [3:0]       inc_base;

  assign btn      = {bus.btn_clr, bus.btn_start, bus.btn_inc, bus.btn_sel, bus.btn_mode};
  assign rise     = btn & ~btn_q;
  assign set_mode = (state_q == SET_TIME) || (state_q == SET_TIMER) || (state_q == SET_ALARM);

`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LIM = CNT_W'(REPEAT_DELAY);
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // Next state, field, idle counter and command strobes from button rises
  always_comb begin
    state_d     = state_q;
    field_sel_d = field_sel_q;
    idle_cnt_d  = idle_cnt_q;
    btn_d       = btn;
    strb_d      = '0;
    inc_fire    = 1'b0;
    inc_base    = 4'd6;
`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
    rep_cnt_d   = rep_cnt_q;
`endif
    if (rise[B_MODE]) begin
      case (state_q)
        DISP_TIME: state_d = SET_TIME;
        SET_TIME:  state_d = STOPWATCH;
        STOPWATCH: state_d = TIMER;
        TIMER:     state_d = SET_TIMER;
        SET_TIMER: state_d = SET_ALARM;
        default:   state_d = DISP_TIME;
      endcase
      field_sel_d = '0;
      idle_cnt_d  = '0;
`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
      rep_cnt_d   = '0;
`endif
    end else begin
      if (rise[B_SEL]) begin
        case (state_q)
          SET_TIME, SET_TIMER: field_sel_d = (field_sel_q == 2'd2) ? 2'd0 : field_sel_q + 2'd1;
          SET_ALARM:           field_sel_d = {1'b0, ~field_sel_q[0]};
          default:             ;
        endcase
      end
`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
      // rep_cnt==0 means "not repeating": a field change parks it until release
      if (!set_mode || !btn[B_INC]) begin
        rep_cnt_d = '0;
      end else if (rise[B_INC]) begin
        inc_fire  = 1'b1;
        rep_cnt_d = CNT_W'(1);
      end else if (field_sel_d != field_sel_q) begin
        rep_cnt_d = '0;
      end else if (rep_cnt_q != '0) begin
        if (rep_cnt_q >= REP_LIM) inc_fire = 1'b1;
        else                      rep_cnt_d = rep_cnt_q + CNT_W'(1);
      end
`else
      inc_fire = set_mode & rise[B_INC];
`endif
      if (inc_fire) begin
        case (state_q)
          SET_TIME:  inc_base = 4'd0;
          SET_TIMER: inc_base = 4'd3;
          default:   inc_base = 4'd6;
        endcase
        strb_d[inc_base + {2'b00, field_sel_d}] = 1'b1;
      end
      if (rise[B_START]) begin
        if (state_q == STOPWATCH) begin
          if (bus.is_stopwatch_running) strb_d[S_SW_STOP]  = 1'b1;
          else                          strb_d[S_SW_START] = 1'b1;
        end else if (state_q == TIMER) begin
          if (bus.is_timer_running) strb_d[S_TM_STOP]  = 1'b1;
          else                      strb_d[S_TM_START] = 1'b1;
        end
      end
      if (rise[B_CLR]) begin
        if (bus.alarm_trigger)       strb_d[S_ALM_RST] = 1'b1;
        else if (state_q == STOPWATCH) strb_d[S_SW_RST] = 1'b1;
        else if (state_q == TIMER)     strb_d[S_TM_RST] = 1'b1;
      end
      if (set_mode) begin
        if ((|rise) || btn[B_INC]) begin
          idle_cnt_d = '0;
        end else if (TIMEOUT != 0 && idle_cnt_q == TO_LAST) begin
          state_d     = DISP_TIME;
          field_sel_d = '0;
          idle_cnt_d  = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end else begin
        idle_cnt_d = '0;
      end
    end
  end

  // One-hot mode levels decoded from the next state so they align with mode_state
  always_comb begin
    mode_lvl_d = '0;
    case (state_d)
      SET_TIME:  mode_lvl_d[0] = 1'b1;
      STOPWATCH: mode_lvl_d[1] = 1'b1;
      TIMER:     mode_lvl_d[2] = 1'b1;
      SET_TIMER: mode_lvl_d[3] = 1'b1;
      SET_ALARM: mode_lvl_d[4] = 1'b1;
      default:   ;
    endcase
  end

  // State, history and output registers
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      state_q     <= DISP_TIME;
      field_sel_q <= '0;
      idle_cnt_q  <= '0;
      btn_q       <= '0;
      strb_q      <= '0;
      mode_lvl_q  <= '0;
    end else begin
      state_q     <= state_d;
      field_sel_q <= field_sel_d;
      idle_cnt_q  <= idle_cnt_d;
      btn_q       <= btn_d;
      strb_q      <= strb_d;
      mode_lvl_q  <= mode_lvl_d;
    end
  end

`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
  // Hold-to-repeat counter
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) rep_cnt_q <= '0;
    else       rep_cnt_q <= rep_cnt_d;
  end
`endif

  assign bus.set_time_mode     = mode_lvl_q[0];
  assign bus.stopwatch_mode    = mode_lvl_q[1];
  assign bus.timer_mode        = mode_lvl_q[2];
  assign bus.set_timer_mode    = mode_lvl_q[3];
  assign bus.set_alarm_mode    = mode_lvl_q[4];
  assign bus.inc_hours         = strb_q[0];
  assign bus.inc_minutes       = strb_q[1];
  assign bus.inc_seconds       = strb_q[2];
  assign bus.inc_timer_hours   = strb_q[3];
  assign bus.inc_timer_minutes = strb_q[4];
  assign bus.inc_timer_seconds = strb_q[5];
  assign bus.inc_alarm_hours   = strb_q[6];
  assign bus.inc_alarm_minutes = strb_q[7];
  assign bus.start_stopwatch   = strb_q[S_SW_START];
  assign bus.stop_stopwatch    = strb_q[S_SW_STOP];
  assign bus.reset_stopwatch   = strb_q[S_SW_RST];
  assign bus.start_timer       = strb_q[S_TM_START];
  assign bus.stop_timer        = strb_q[S_TM_STOP];
  assign bus.reset_timer       = strb_q[S_TM_RST];
  assign bus.alarm_reset       = strb_q[S_ALM_RST];
  assign bus.field_sel         = field_sel_q;
  assign bus.mode_state        = state_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed vector table, hand sequences for
// timeout / auto-repeat / async reset, and random stimulus vs. a reference model.
module tb_clock_mode_ctrl;
  localparam int RD = 2;
  localparam int TO = 30;

  // strobe positions in the observed word
  localparam int IH = 0, IM = 1, IS = 2, ITH = 3, ITM = 4, ITS = 5, IAH = 6, IAM = 7;
  localparam int SWS = 8, SWP = 9, SWR = 10, TS = 11, TP = 12, TR = 13, ALR = 14;
  // button masks {clr,start,inc,sel,mode}
  localparam logic [4:0] M = 5'b00001, S = 5'b00010, I = 5'b00100, T = 5'b01000, C = 5'b10000;

  logic clk_1Hz = 1'b0;
  logic reset   = 1'b1;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  bit   mdl_on  = 1'b0;
  logic [4:0] rb;
  logic [2:0] rs;

  clock_mode_ctrl_if bus();

  clock_mode_ctrl #(.REPEAT_DELAY(RD), .TIMEOUT(TO), .CNT_W(6)) dut (
    .clk_1Hz(clk_1Hz),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  typedef struct {
    int         mode;
    int         field;
    int         idle;
    int         rep;
    logic [4:0] prev;
    logic [14:0] strb;
  } model_t;

  typedef struct {
    logic [4:0] btn;
    logic [2:0] st;    // {alarm_trigger, is_timer_running, is_stopwatch_running}
    int         mode;
    int         field;
    int         sbit;  // -1: no strobe
  } vec_t;

  model_t mdl;

  function automatic logic [14:0] sb(input int n);
    logic [14:0] one = 15'd1;
    return (n < 0) ? 15'd0 : (one << n);
  endfunction

  function automatic logic [14:0] strb_obs();
    return {bus.alarm_reset, bus.reset_timer, bus.stop_timer, bus.start_timer,
            bus.reset_stopwatch, bus.stop_stopwatch, bus.start_stopwatch,
            bus.inc_alarm_minutes, bus.inc_alarm_hours,
            bus.inc_timer_seconds, bus.inc_timer_minutes, bus.inc_timer_hours,
            bus.inc_seconds, bus.inc_minutes, bus.inc_hours};
  endfunction

  function automatic logic [24:0] obs();
    return {bus.mode_state, bus.field_sel, bus.set_alarm_mode, bus.set_timer_mode,
            bus.timer_mode, bus.stopwatch_mode, bus.set_time_mode, strb_obs()};
  endfunction

  function automatic logic [24:0] mdl_word(input model_t m);
    logic [4:0] one = 5'd1;
    logic [4:0] lvl = (m.mode == 0) ? 5'd0 : (one << (m.mode - 1));
    return {3'(m.mode), 2'(m.field), lvl, m.strb};
  endfunction

  function automatic model_t mdl_reset();
    model_t r;
    r.mode = 0; r.field = 0; r.idle = 0; r.rep = 0; r.prev = '0; r.strb = '0;
    return r;
  endfunction

  // One clock of the UI rules, in terms of mode numbers and field counts
  function automatic model_t step(input model_t cur, input logic [4:0] b, input logic [2:0] st);
    model_t     n = cur;
    logic [4:0] r = b & ~cur.prev;
    bit         set_m = (cur.mode == 1) || (cur.mode == 4) || (cur.mode == 5);
    int         nfields = (cur.mode == 1 || cur.mode == 4) ? 3 : (cur.mode == 5) ? 2 : 0;
    bit         fire = 0;
    n.strb = '0;
    n.prev = b;
    if (r[0]) begin
      n.mode = (cur.mode + 1) % 6; n.field = 0; n.idle = 0; n.rep = 0;
      return n;
    end
    if (r[1] && nfields != 0) n.field = (cur.field + 1) % nfields;
`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
    if (!set_m || !b[2]) n.rep = 0;
    else if (r[2]) begin fire = 1; n.rep = 1; end
    else if (n.field != cur.field) n.rep = 0;
    else if (cur.rep > 0) begin
      if (cur.rep >= RD) fire = 1;
      else n.rep = cur.rep + 1;
    end
`else
    fire = set_m && r[2];
`endif
    if (fire) n.strb[((cur.mode == 1) ? 0 : (cur.mode == 4) ? 3 : 6) + n.field] = 1'b1;
    if (r[3]) begin
      if (cur.mode == 2) n.strb[st[0] ? SWP : SWS] = 1'b1;
      if (cur.mode == 3) n.strb[st[1] ? TP : TS] = 1'b1;
    end
    if (r[4]) begin
      if (st[2]) n.strb[ALR] = 1'b1;
      else if (cur.mode == 2) n.strb[SWR] = 1'b1;
      else if (cur.mode == 3) n.strb[TR] = 1'b1;
    end
    if (set_m) begin
      if (r != 0 || b[2]) n.idle = 0;
      else if (TO != 0 && cur.idle == TO - 1) begin n.mode = 0; n.field = 0; n.idle = 0; end
      else n.idle = cur.idle + 1;
    end else n.idle = 0;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] b, input logic [2:0] st);
    bus.btn_mode             = b[0];
    bus.btn_sel              = b[1];
    bus.btn_inc              = b[2];
    bus.btn_start            = b[3];
    bus.btn_clr              = b[4];
    bus.is_stopwatch_running = st[0];
    bus.is_timer_running     = st[1];
    bus.alarm_trigger        = st[2];
  endtask

  task automatic pulse(input logic [4:0] b, input int times);
    for (int k = 0; k < times; k++) begin
      drive(b, 3'b000);
      @(negedge clk_1Hz);
      drive(5'b0, 3'b000);
      @(negedge clk_1Hz);
    end
  endtask

  // Reference model advances on the same edges as the DUT
  always @(posedge clk_1Hz or posedge reset) begin
    if (reset) mdl <= mdl_reset();
    else       mdl <= step(mdl, {bus.btn_clr, bus.btn_start, bus.btn_inc, bus.btn_sel, bus.btn_mode},
                           {bus.alarm_trigger, bus.is_timer_running, bus.is_stopwatch_running});
  end

  // Every-cycle comparison against the model
  always @(negedge clk_1Hz) begin
    if (mdl_on && !reset) chk("model", 32'(obs()), 32'(mdl_word(mdl)));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    logic [6:0] rep_exp;

    drive(5'b0, 3'b000);
    repeat (2) @(negedge clk_1Hz);
    chk("reset_state", 32'(obs()), 32'd0);
    reset  = 1'b0;
    mdl_on = 1'b1;

    // mode cycling with releases
    tbl.push_back('{M, 3'b000, 1, 0, -1}); tbl.push_back('{0, 3'b000, 1, 0, -1});
    tbl.push_back('{M, 3'b000, 2, 0, -1}); tbl.push_back('{0, 3'b000, 2, 0, -1});
    tbl.push_back('{M, 3'b000, 3, 0, -1}); tbl.push_back('{0, 3'b000, 3, 0, -1});
    tbl.push_back('{M, 3'b000, 4, 0, -1}); tbl.push_back('{0, 3'b000, 4, 0, -1});
    tbl.push_back('{M, 3'b000, 5, 0, -1}); tbl.push_back('{0, 3'b000, 5, 0, -1});
    tbl.push_back('{M, 3'b000, 0, 0, -1}); tbl.push_back('{0, 3'b000, 0, 0, -1});
    // sel / inc ignored in DISP_TIME
    tbl.push_back('{S, 3'b000, 0, 0, -1}); tbl.push_back('{0, 3'b000, 0, 0, -1});
    tbl.push_back('{I, 3'b000, 0, 0, -1}); tbl.push_back('{0, 3'b000, 0, 0, -1});
    // SET_TIME: two sels then inc -> seconds
    tbl.push_back('{M, 3'b000, 1, 0, -1}); tbl.push_back('{0, 3'b000, 1, 0, -1});
    tbl.push_back('{S, 3'b000, 1, 1, -1}); tbl.push_back('{0, 3'b000, 1, 1, -1});
    tbl.push_back('{S, 3'b000, 1, 2, -1}); tbl.push_back('{0, 3'b000, 1, 2, -1});
    tbl.push_back('{I, 3'b000, 1, 2, IS}); tbl.push_back('{0, 3'b000, 1, 2, -1});
    // STOPWATCH start / stop / reset
    tbl.push_back('{M, 3'b000, 2, 0, -1});  tbl.push_back('{0, 3'b000, 2, 0, -1});
    tbl.push_back('{T, 3'b000, 2, 0, SWS}); tbl.push_back('{0, 3'b001, 2, 0, -1});
    tbl.push_back('{T, 3'b001, 2, 0, SWP}); tbl.push_back('{0, 3'b001, 2, 0, -1});
    tbl.push_back('{C, 3'b000, 2, 0, SWR}); tbl.push_back('{0, 3'b000, 2, 0, -1});
    // TIMER: alarm ack has priority over reset_timer
    tbl.push_back('{M, 3'b000, 3, 0, -1});  tbl.push_back('{0, 3'b000, 3, 0, -1});
    tbl.push_back('{C, 3'b100, 3, 0, ALR}); tbl.push_back('{0, 3'b100, 3, 0, -1});
    tbl.push_back('{C, 3'b000, 3, 0, TR});  tbl.push_back('{0, 3'b000, 3, 0, -1});
    tbl.push_back('{T, 3'b010, 3, 0, TP});  tbl.push_back('{0, 3'b010, 3, 0, -1});
    tbl.push_back('{T, 3'b000, 3, 0, TS});  tbl.push_back('{0, 3'b000, 3, 0, -1});
    // mode wins over simultaneous start/clr
    tbl.push_back('{M | T | C, 3'b000, 4, 0, -1}); tbl.push_back('{0, 3'b000, 4, 0, -1});
    // SET_TIMER: sel applied before inc in the same cycle, wrap at 3 fields
    tbl.push_back('{S | I, 3'b000, 4, 1, ITM}); tbl.push_back('{0, 3'b000, 4, 1, -1});
    tbl.push_back('{S, 3'b000, 4, 2, -1});      tbl.push_back('{0, 3'b000, 4, 2, -1});
    tbl.push_back('{I, 3'b000, 4, 2, ITS});     tbl.push_back('{0, 3'b000, 4, 2, -1});
    tbl.push_back('{S, 3'b000, 4, 0, -1});      tbl.push_back('{0, 3'b000, 4, 0, -1});
    // SET_ALARM: two fields
    tbl.push_back('{M, 3'b000, 5, 0, -1});   tbl.push_back('{0, 3'b000, 5, 0, -1});
    tbl.push_back('{S, 3'b000, 5, 1, -1});   tbl.push_back('{0, 3'b000, 5, 1, -1});
    tbl.push_back('{I, 3'b000, 5, 1, IAM});  tbl.push_back('{0, 3'b000, 5, 1, -1});
    tbl.push_back('{S, 3'b000, 5, 0, -1});   tbl.push_back('{0, 3'b000, 5, 0, -1});
    tbl.push_back('{I, 3'b000, 5, 0, IAH});  tbl.push_back('{0, 3'b000, 5, 0, -1});
    tbl.push_back('{C, 3'b100, 5, 0, ALR});  tbl.push_back('{0, 3'b000, 5, 0, -1});
    tbl.push_back('{M, 3'b000, 0, 0, -1});   tbl.push_back('{0, 3'b000, 0, 0, -1});

    foreach (tbl[i]) begin
      drive(tbl[i].btn, tbl[i].st);
      @(negedge clk_1Hz);
      chk($sformatf("tbl[%0d]", i), {12'd0, bus.mode_state, bus.field_sel, strb_obs()},
          {12'd0, 3'(tbl[i].mode), 2'(tbl[i].field), sb(tbl[i].sbit)});
    end

    // Timeout from SET_ALARM with no activity: entry edge E0, return at E30
    pulse(M, 5);
    for (int k = 2; k <= 30; k++) begin
      @(negedge clk_1Hz);
      if (k == 29) chk("to_before", 32'(bus.mode_state), 32'd5);
      if (k == 30) chk("to_return", {27'd0, bus.mode_state, bus.field_sel}, 32'd0);
    end

    // Same, with a sel rise at cycle 20 restarting the idle count
    pulse(M, 5);
    for (int k = 2; k <= 50; k++) begin
      @(negedge clk_1Hz);
      if (k == 19) drive(S, 3'b000);
      if (k == 20) drive(5'b0, 3'b000);
      if (k == 30) chk("to_delayed", 32'(bus.mode_state), 32'd5);
      if (k == 49) chk("to_late_before", {27'd0, bus.mode_state, bus.field_sel}, {27'd0, 3'd5, 2'd1});
      if (k == 50) chk("to_late_return", {27'd0, bus.mode_state, bus.field_sel}, 32'd0);
    end

    // Hold btn_inc for 6 cycles in SET_TIMER, minutes field
    pulse(M, 4);
    pulse(S, 1);
`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
    rep_exp = 7'b0111101;
`else
    rep_exp = 7'b0000001;
`endif
    drive(I, 3'b000);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_1Hz);
      chk($sformatf("hold[%0d]", k), 32'(strb_obs()), rep_exp[k-1] ? 32'(sb(ITM)) : 32'd0);
      if (k == 6) drive(5'b0, 3'b000);
    end

    // Async reset with a strobe in flight
    pulse(M, 2);
    pulse(M, 2);
    drive(T, 3'b000);
    @(posedge clk_1Hz);
    #2;
    chk("rst_inflight", 32'(strb_obs()), 32'(sb(SWS)));
    reset = 1'b1;
    #1;
    chk("rst_async", 32'(obs()), 32'd0);
    @(negedge clk_1Hz);
    drive(5'b0, 3'b000);
    reset = 1'b0;
    @(negedge clk_1Hz);
    chk("rst_release", 32'(obs()), 32'd0);

    // Random stimulus, with quiet stretches so timeouts occur
    rb = '0;
    rs = '0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 >= 450) rb = '0;
      else begin
        if ($urandom_range(0, 15) == 0) rb[0] = ~rb[0];
        for (int j = 1; j < 5; j++) if ($urandom_range(0, 3) == 0) rb[j] = ~rb[j];
      end
      if ($urandom_range(0, 7) == 0) rs = 3'($urandom_range(0, 7));
      drive(rb, rs);
      @(negedge clk_1Hz);
    end

    drive(5'b0, 3'b000);
    @(negedge clk_1Hz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
User-interface sequencer in front of the clock datapath. It turns five raw push-buttons into the datapath's mode levels and one-cycle command strobes: set time, stopwatch, timer, set timer, set alarm, increments, start/stop/reset and alarm acknowledge. It owns the mode state machine, per-mode field selection, hold-to-repeat and the inactivity timeout, so the datapath only ever sees one mode active at a time.

Parameters:
REPEAT_DELAY, 2, cycles btn_inc must be held before auto-repeat starts (>=1)
TIMEOUT, 30, idle cycles in a set mode before returning to DISP_TIME; 0 disables
CNT_W, 6, width of the idle/repeat counters; must hold max(TIMEOUT, REPEAT_DELAY)

Ports:
clk_1Hz  in  1  system tick
reset  in  1  async, active-high
btn_mode  in  1  cycle mode (level, synchronous to clk_1Hz)
btn_sel  in  1  cycle edit field
btn_inc  in  1  increment selected field
btn_start  in  1  start/stop toggle
btn_clr  in  1  stopwatch/timer reset; alarm acknowledge
is_stopwatch_running  in  1  status from datapath
is_timer_running  in  1  status from datapath
alarm_trigger  in  1  status from datapath
set_time_mode, stopwatch_mode, timer_mode, set_timer_mode, set_alarm_mode  out  1 each  mode levels
inc_hours, inc_minutes, inc_seconds  out  1 each  time increment strobes
inc_timer_hours, inc_timer_minutes, inc_timer_seconds  out  1 each  timer increment strobes
inc_alarm_hours, inc_alarm_minutes  out  1 each  alarm increment strobes
start_stopwatch, stop_stopwatch, reset_stopwatch  out  1 each  stopwatch command strobes
start_timer, stop_timer, reset_timer  out  1 each  timer command strobes
alarm_reset  out  1  alarm acknowledge strobe
field_sel  out  2  0=hours, 1=minutes, 2=seconds
mode_state  out  3  current state encoding, for display mux

Behaviour:
- Reset is asynchronous and active-high; the clock is clk_1Hz.
- Reset state: all outputs 0, state DISP_TIME(0), field_sel=0, all counters 0, button history regs 0.
- Edge detect: each button is registered. A rise is btn=1 with btn_q=0 at a clock edge. All outputs are registered and the strobe for that rise is high for exactly the following cycle (1-cycle latency).
- States and encodings: DISP_TIME=0, SET_TIME=1, STOPWATCH=2, TIMER=3, SET_TIMER=4, SET_ALARM=5.
- btn_mode rise advances 0→1→2→3→4→5→0, sets field_sel=0 and clears the idle counter.
- Mode levels are one-hot: set_time_mode in SET_TIME, stopwatch_mode in STOPWATCH, timer_mode in TIMER, set_timer_mode in SET_TIMER, set_alarm_mode in SET_ALARM. All are 0 in DISP_TIME.
- btn_sel rise, SET_TIME/SET_TIMER: field_sel cycles 0→1→2→0.
- btn_sel rise, SET_ALARM: field_sel cycles 0→1→0.
- btn_sel rise, other states: ignored.
- btn_inc rise in a set mode: one-cycle strobe on the inc_* output matching mode and field_sel. Never more than one inc_* high in a cycle.
- btn_start rise in STOPWATCH: stop_stopwatch if is_stopwatch_running, else start_stopwatch.
- btn_start rise in TIMER: stop_timer if is_timer_running, else start_timer.
- btn_start rise in other states: ignored.
- btn_clr rise with alarm_trigger=1, any state: alarm_reset strobe only. This has priority and suppresses reset_stopwatch/reset_timer.
- btn_clr rise otherwise: reset_stopwatch in STOPWATCH, reset_timer in TIMER, ignored elsewhere.
- Simultaneous rises in one cycle: btn_mode wins and all other strobes are suppressed that cycle. btn_sel is applied before btn_inc, so the increment targets the new field.
- Idle timeout: only in SET_TIME, SET_TIMER and SET_ALARM.
  - idle_cnt increments each cycle.
  - Any button rise, or btn_inc held high, clears it.
  - When idle_cnt==TIMEOUT-1 with no activity: next state DISP_TIME, field_sel=0, idle_cnt=0.
  - TIMEOUT=0: never times out.
- Strobes are always 1 cycle, and a new rise needs a release first. This guarantees the datapath's own edge detectors see a low between successive commands.
- Reset mid-operation: immediate return to reset state; in-flight strobes are dropped.

Optional Feature:
CLOCK_MODE_CTRL_AUTOREPEAT_EN
- Defined: while btn_inc stays high in a set mode, rep_cnt counts held cycles. Once rep_cnt reaches REPEAT_DELAY, the selected inc_* is high every cycle until btn_inc falls, mode changes, or field changes. rep_cnt clears on release.
- Undefined: btn_inc produces exactly one strobe per rise; rep_cnt logic is absent.

Test Plan:
- Reset, then 6 btn_mode pulses (1 cycle high, 1 low each) → mode_state 1,2,3,4,5,0; exactly one mode level high in states 1-5; none in 0.
- In SET_TIME, btn_sel pulse twice then btn_inc pulse → field_sel=2; inc_seconds high exactly 1 cycle; no other inc_* high.
- In STOPWATCH with is_stopwatch_running=0, btn_start pulse → start_stopwatch 1 cycle. Drive is_stopwatch_running=1, pulse again → stop_stopwatch 1 cycle.
- alarm_trigger=1 in TIMER, btn_clr pulse → alarm_reset 1 cycle; reset_timer stays 0.
- SET_ALARM with TIMEOUT=30, no buttons → mode_state returns to 0 after 30 cycles, field_sel=0. Repeat with a btn_sel pulse at cycle 20 → return is delayed to 30 cycles after that pulse.
- With CLOCK_MODE_CTRL_AUTOREPEAT_EN and REPEAT_DELAY=2, hold btn_inc 6 cycles in SET_TIMER field 1 → inc_timer_minutes high on cycle 1, low until the hold reaches 2 cycles, then high each cycle until release. Without the macro: a single 1-cycle strobe.
